// File: rtl/rc4_prga_decrypt.sv
// rc4_prga_decrypt: RC4 PRGA keystream generator XORed with the encrypted ROM into the decrypted RAM
// Ports: clk, reset (sync, active-high), start (level, S-memory holds scheduled key)
//        s_addr/s_wdata/s_wren/s_q : S-memory port, one access per cycle
//        rom_addr/rom_q            : encrypted-message ROM
//        dec_addr/dec_wdata/dec_wren : decrypted-message RAM
//        done                      : all MSG_LEN bytes written, held until reset
module rc4_prga_decrypt #(
    parameter int MSG_LEN = 32,
    parameter int MSG_AW  = 5,
    parameter int RD_WAIT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [7:0]        s_addr,
    output logic [7:0]        s_wdata,
    output logic              s_wren,
    input  logic [7:0]        s_q,
    output logic [MSG_AW-1:0] rom_addr,
    input  logic [7:0]        rom_q,
    output logic [MSG_AW-1:0] dec_addr,
    output logic [7:0]        dec_wdata,
    output logic              dec_wren,
    output logic              done
);
    localparam int WW = (RD_WAIT > 1) ? $clog2(RD_WAIT) : 1;
    localparam logic [WW-1:0] W_LAST = WW'(RD_WAIT - 1);
    localparam logic [MSG_AW:0] K_LAST = (MSG_AW + 1)'(MSG_LEN - 1);
    typedef enum logic [3:0] {
        IDLE, INC_I, WAIT_SI, ADD_J, WAIT_SJ, WR_SI, WR_SJ, RD_F, WAIT_F, WR_DEC, NEXT_K, DONE
    } state_t;
    state_t state_q, state_d;
    logic [7:0] i_q, i_d, j_q, j_d, si_q, si_d, sj_q, sj_d;
    logic [MSG_AW:0] k_q, k_d;
    logic [WW-1:0] w_q, w_d;
    logic [7:0] s_addr_q, s_addr_d, s_wdata_q, s_wdata_d, dec_wdata_q, dec_wdata_d;
    logic [MSG_AW-1:0] rom_addr_q, rom_addr_d, dec_addr_q, dec_addr_d;
    logic s_wren_q, s_wren_d, dec_wren_q, dec_wren_d, done_q, done_d;
    always_comb begin
        state_d     = state_q;
        i_d         = i_q;
        j_d         = j_q;
        si_d        = si_q;
        sj_d        = sj_q;
        k_d         = k_q;
        w_d         = w_q;
        s_addr_d    = s_addr_q;
        s_wdata_d   = s_wdata_q;
        rom_addr_d  = rom_addr_q;
        dec_addr_d  = dec_addr_q;
        dec_wdata_d = dec_wdata_q;
        s_wren_d    = 1'b0;
        dec_wren_d  = 1'b0;
        done_d      = done_q;
        case (state_q)
            IDLE: state_d = start ? INC_I : IDLE;
            INC_I: begin
                i_d      = i_q + 8'd1;
                s_addr_d = i_q + 8'd1;
                w_d      = '0;
                state_d  = WAIT_SI;
            end
            WAIT_SI, WAIT_SJ, WAIT_F: begin
                w_d = w_q + 1'b1;
                if (w_q == W_LAST)
                    state_d = (state_q == WAIT_SI) ? ADD_J : (state_q == WAIT_SJ) ? WR_SI : WR_DEC;
            end
            ADD_J: begin
                si_d     = s_q;
                j_d      = j_q + s_q;
                s_addr_d = j_q + s_q;
                w_d      = '0;
                state_d  = WAIT_SJ;
            end
            WR_SI: begin
                sj_d      = s_q;
                s_addr_d  = i_q;
                s_wdata_d = s_q;
                s_wren_d  = 1'b1;
                state_d   = WR_SJ;
            end
            WR_SJ: begin
                s_addr_d  = j_q;
                s_wdata_d = si_q;
                s_wren_d  = 1'b1;
                state_d   = RD_F;
            end
            RD_F: begin
                s_addr_d   = si_q + sj_q;
                rom_addr_d = k_q[MSG_AW-1:0];
                w_d        = '0;
                state_d    = WAIT_F;
            end
            WR_DEC: begin
                dec_addr_d  = k_q[MSG_AW-1:0];
                dec_wdata_d = s_q ^ rom_q;
                dec_wren_d  = 1'b1;
                state_d     = NEXT_K;
            end
            NEXT_K: begin
                k_d     = (k_q == K_LAST) ? k_q : k_q + 1'b1;
                state_d = (k_q == K_LAST) ? DONE : INC_I;
            end
            DONE: done_d = 1'b1;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            i_q         <= '0;
            j_q         <= '0;
            si_q        <= '0;
            sj_q        <= '0;
            k_q         <= '0;
            w_q         <= '0;
            s_addr_q    <= '0;
            s_wdata_q   <= '0;
            s_wren_q    <= 1'b0;
            rom_addr_q  <= '0;
            dec_addr_q  <= '0;
            dec_wdata_q <= '0;
            dec_wren_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            i_q         <= i_d;
            j_q         <= j_d;
            si_q        <= si_d;
            sj_q        <= sj_d;
            k_q         <= k_d;
            w_q         <= w_d;
            s_addr_q    <= s_addr_d;
            s_wdata_q   <= s_wdata_d;
            s_wren_q    <= s_wren_d;
            rom_addr_q  <= rom_addr_d;
            dec_addr_q  <= dec_addr_d;
            dec_wdata_q <= dec_wdata_d;
            dec_wren_q  <= dec_wren_d;
            done_q      <= done_d;
        end
    end
    assign s_addr    = s_addr_q;
    assign s_wdata   = s_wdata_q;
    assign s_wren    = s_wren_q;
    assign rom_addr  = rom_addr_q;
    assign dec_addr  = dec_addr_q;
    assign dec_wdata = dec_wdata_q;
    assign dec_wren  = dec_wren_q;
    assign done      = done_q;
endmodule

// File: tb/tb_rc4_prga_decrypt.sv
// tb_rc4_prga_decrypt: randomized RC4 decryption runs checked against a behavioural RC4 model
module tb_rc4_prga_decrypt;
    localparam int MSG_LEN = 32;
    localparam int MSG_AW  = 5;
    localparam int RD_WAIT = 2;
    localparam int LAT     = 1 + MSG_LEN * (7 + 3 * RD_WAIT);
    logic clk = 1'b0, reset = 1'b1, start = 1'b0;
    logic [7:0] s_addr, s_wdata, s_q, rom_q, dec_wdata;
    logic [MSG_AW-1:0] rom_addr, dec_addr;
    logic s_wren, dec_wren, done;
    logic [7:0] s_mem [256];
    logic [7:0] s_init [256];
    logic [7:0] exp_s [256];
    logic [7:0] rom [MSG_LEN];
    logic [7:0] dec [MSG_LEN];
    logic [7:0] pt [MSG_LEN];
    logic [7:0] exp_dec [MSG_LEN];
    int errs = 0, checks = 0;
    int s_wr_cnt = 0, dec_wr_cnt = 0, viol = 0, s_run = 0;
    logic prev_dec = 1'b0;
    always #5 clk = ~clk;
    rc4_prga_decrypt #(.MSG_LEN(MSG_LEN), .MSG_AW(MSG_AW), .RD_WAIT(RD_WAIT)) dut (
        .clk(clk), .reset(reset), .start(start),
        .s_addr(s_addr), .s_wdata(s_wdata), .s_wren(s_wren), .s_q(s_q),
        .rom_addr(rom_addr), .rom_q(rom_q),
        .dec_addr(dec_addr), .dec_wdata(dec_wdata), .dec_wren(dec_wren),
        .done(done)
    );
    always @(posedge clk) begin
        s_q <= s_mem[s_addr];
        rom_q <= rom[rom_addr];
        if (s_wren) s_mem[s_addr] = s_wdata;
        if (dec_wren) dec[dec_addr] = dec_wdata;
    end
    always @(negedge clk) begin
        if (s_wren) s_wr_cnt++;
        if (dec_wren) dec_wr_cnt++;
        s_run = s_wren ? s_run + 1 : 0;
        if (s_run > 2) viol++;
        if (dec_wren && prev_dec) viol++;
        prev_dec = dec_wren;
    end
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask
    task automatic ident();
        for (int n = 0; n < 256; n++) s_init[n] = 8'(n);
    endtask
    task automatic ksa(input logic [23:0] key);
        int j = 0;
        logic [7:0] t;
        ident();
        for (int n = 0; n < 256; n++) begin
            j = (j + s_init[n] + int'((key >> (8 * (2 - n % 3))) & 24'hff)) % 256;
            t = s_init[n];
            s_init[n] = s_init[j];
            s_init[j] = t;
        end
    endtask
    task automatic model();
        int i = 0, j = 0;
        logic [7:0] s [256];
        logic [7:0] t;
        s = s_init;
        for (int k = 0; k < MSG_LEN; k++) begin
            i = (i + 1) % 256;
            j = (j + s[i]) % 256;
            t = s[i];
            s[i] = s[j];
            s[j] = t;
            exp_dec[k] = s[(int'(s[i]) + int'(s[j])) % 256] ^ rom[k];
        end
        exp_s = s;
    endtask
    task automatic encrypt_random();
        for (int k = 0; k < MSG_LEN; k++) begin
            pt[k] = 8'($urandom);
            rom[k] = 8'h00;
        end
        model();
        for (int k = 0; k < MSG_LEN; k++) rom[k] = pt[k] ^ exp_dec[k];
        model();
    endtask
    task automatic load();
        for (int n = 0; n < 256; n++) s_mem[n] = s_init[n];
        for (int k = 0; k < MSG_LEN; k++) dec[k] = 8'hEE;
    endtask
    task automatic do_reset();
        @(negedge clk);
        start = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask
    task automatic do_run(input bit hold, output int n);
        @(negedge clk);
        s_wr_cnt = 0;
        dec_wr_cnt = 0;
        start = 1'b1;
        @(posedge clk);
        n = 0;
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (!hold) start = 1'b0;
        end while (!done && n < 3 * LAT);
    endtask
    task automatic check_dec(input string tag);
        for (int k = 0; k < MSG_LEN; k++) check($sformatf("%s_dec%0d", tag, k), dec[k], pt[k]);
    endtask
    task automatic check_s(input string tag);
        int bad = 0;
        for (int n = 0; n < 256; n++) if (s_mem[n] !== exp_s[n]) bad++;
        check($sformatf("%s_smem_bad", tag), bad, 0);
    endtask
    initial begin
        int n;
        repeat (3) @(negedge clk);
        check("rst_done", done, 0);
        check("rst_s_wren", s_wren, 0);
        check("rst_dec_wren", dec_wren, 0);
        check("rst_s_addr", s_addr, 0);
        check("rst_s_wdata", s_wdata, 0);
        check("rst_rom_addr", rom_addr, 0);
        check("rst_dec_addr", dec_addr, 0);
        check("rst_dec_wdata", dec_wdata, 0);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        check("idle_hold_wren", s_wren, 0);
        check("idle_hold_done", done, 0);
        ident();
        for (int k = 0; k < MSG_LEN; k++) rom[k] = 8'h00;
        model();
        load();
        do_run(1'b0, n);
        check("t1_latency", n, LAT);
        check("t1_dec0", dec[0], 8'h02);
        check("t1_dec1", dec[1], 8'h05);
        for (int k = 0; k < MSG_LEN; k++) check($sformatf("t1_dec%0d", k), dec[k], exp_dec[k]);
        check_s("t1");
        check("t1_s_writes", s_wr_cnt, 2 * MSG_LEN);
        check("t1_dec_writes", dec_wr_cnt, MSG_LEN);
        do_reset();
        for (int k = 0; k < MSG_LEN; k++) rom[k] = 8'h61;
        model();
        load();
        do_run(1'b0, n);
        check("t2_latency", n, LAT);
        check("t2_dec0", dec[0], 8'h63);
        check("t2_dec1", dec[1], 8'h64);
        do_reset();
        ksa(24'h000000);
        encrypt_random();
        load();
        do_run(1'b0, n);
        check("t3_latency", n, LAT);
        check_dec("t3");
        check_s("t3");
        do_reset();
        load();
        @(negedge clk);
        dec_wr_cnt = 0;
        start = 1'b1;
        n = 0;
        while (dec_wr_cnt < 10 && n < 3 * LAT) begin
            @(negedge clk);
            n++;
        end
        check("t4_reached_k10", dec_wr_cnt, 10);
        start = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("t4_rst_s_wren", s_wren, 0);
        check("t4_rst_dec_wren", dec_wren, 0);
        check("t4_rst_done", done, 0);
        check("t4_rst_s_addr", s_addr, 0);
        reset = 1'b0;
        load();
        do_run(1'b0, n);
        check("t4_latency", n, LAT);
        check_dec("t4");
        do_reset();
        ksa(24'($urandom));
        encrypt_random();
        load();
        do_run(1'b1, n);
        check("t5_latency", n, LAT);
        s_wr_cnt = 0;
        dec_wr_cnt = 0;
        repeat (40) @(negedge clk);
        check("t5_done_held", done, 1);
        check("t5_no_writes", s_wr_cnt + dec_wr_cnt, 0);
        check_dec("t5a");
        do_reset();
        load();
        do_run(1'b0, n);
        check_dec("t5b");
        check_s("t5b");
        for (int r = 0; r < 2; r++) begin
            do_reset();
            ksa(24'($urandom));
            encrypt_random();
            load();
            do_run(1'b0, n);
            check($sformatf("rnd%0d_latency", r), n, LAT);
            check_dec($sformatf("rnd%0d", r));
        end
        check("strobe_spacing", viol, 0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
